// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the N:1 scanning mux.
// Optional feature macro used elsewhere in this slice: MUX_PARITY_EN.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Channel-index width: clog2 of the channel count, never narrower than 1 bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of 4:1 levels needed so that 4**levels covers every channel.
  function automatic int tree_levels(input int n);
    int lvls = 1;
    int span = 4;
    while (span < n) begin
      span = span * 4;
      lvls++;
    end
    return lvls;
  endfunction

  // Index of the first node of level 'lvl' in the flattened tree array.
  // Level 0 holds the leaves, level 'levels' holds the single root node.
  function automatic int level_base(input int levels, input int lvl);
    int base = 0;
    for (int i = 0; i < lvl; i++) begin
      base += 1 << (2 * (levels - i));
    end
    return base;
  endfunction

endpackage

// File: rtl/mux_nto1_scan_if.sv
// Data/handshake bundle between the parallel lanes, the mux and its consumer.
// MUX_PARITY_EN adds the registered out_par signal.
interface mux_nto1_scan_if
  import mux_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] din;
  logic                     in_valid;
  logic                     in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;
  logic                     sel_err;
`ifdef MUX_PARITY_EN
  logic                     out_par;
`endif

  // Producer/consumer side.
  modport master (
    output din, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid, sel_err
`ifdef MUX_PARITY_EN
    , input out_par
`endif
  );

  // Mux side.
  modport slave (
    input  din, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid, sel_err
`ifdef MUX_PARITY_EN
    , output out_par
`endif
  );

endinterface

// File: rtl/mux_nto1_scan_stage4.sv
// Combinational W-bit 4:1 mux; the building block of the selection tree.
module mux_stage4 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] d3_i,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] y_o
);

  // Pick one of four inputs by the 2-bit select.
  always_comb begin
    // NOTE: the output is assigned before the case so no path leaves it unassigned (no latch).
    y_o = d0_i;
    case (sel_i)
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      2'd3:    y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// N-channel, W-bit registered mux with valid/ready output, round-robin scan
// mode and out-of-range select detection. Sits between parallel lanes and a
// single serial consumer. Define MUX_PARITY_EN to add the out_par output.
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst,
  mux_nto1_scan_if.slave bus
);

  localparam int SEL_W  = sel_width(NUM_CH);
  localparam int LEVELS = tree_levels(NUM_CH);
  localparam int LEAVES = 1 << (2 * LEVELS);
  localparam int ROOT   = level_base(LEVELS, LEVELS);

  localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  // Flattened selection tree: leaves first, then each level's outputs, root last.
  logic [DATA_W-1:0]   node [ROOT + 1];
  logic [2*LEVELS-1:0] tree_sel;

  logic [SEL_W-1:0]  ch;
  logic              in_ready;
  logic              capture;
  logic              mode_edge;
  logic              out_of_range;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q,   out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              sel_err_q,  sel_err_d;
  logic [SEL_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic              mode_q;
`ifdef MUX_PARITY_EN
  logic              out_par_q, out_par_d;
`endif

  // Leaves: real channels from the packed bus, padding leaves tied to zero.
  for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
    if (k < NUM_CH) begin : g_used
      assign node[k] = bus.din[k*DATA_W +: DATA_W];
    end else begin : g_tied
      assign node[k] = '0;
    end
  end

  // Each level consumes two select bits, least significant pair at the leaves.
  assign tree_sel = (2 * LEVELS)'(ch);

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int IN_BASE  = level_base(LEVELS, l);
    localparam int OUT_BASE = level_base(LEVELS, l + 1);
    localparam int N_OUT    = 1 << (2 * (LEVELS - 1 - l));
    for (genvar j = 0; j < N_OUT; j++) begin : g_node
      mux_stage4 #(.DATA_W(DATA_W)) u_stage (
        .d0_i  (node[IN_BASE + 4*j]),
        .d1_i  (node[IN_BASE + 4*j + 1]),
        .d2_i  (node[IN_BASE + 4*j + 2]),
        .d3_i  (node[IN_BASE + 4*j + 3]),
        .sel_i (tree_sel[2*l +: 2]),
        .y_o   (node[OUT_BASE + j])
      );
    end
  end

  // One-entry output register: accept whenever it is empty or being drained.
  assign in_ready  = !out_valid_q || bus.out_ready;
  assign capture   = bus.in_valid && in_ready;

  // Entering scan mode restarts the round-robin at channel 0 immediately.
  assign mode_edge = (bus.mode == MODE_SCAN) && (mode_q == MODE_DIRECT);
  assign ch        = (bus.mode == MODE_SCAN) ? (mode_edge ? '0 : scan_cnt_q) : bus.sel;

  // Only reachable when NUM_CH is not a power of two.
  assign out_of_range = (bus.mode == MODE_DIRECT) && ({1'b0, bus.sel} >= NUM_CH_X);

  // Next-state for the output register, error flag and scan counter.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    scan_cnt_d  = scan_cnt_q;
`ifdef MUX_PARITY_EN
    out_par_d   = out_par_q;
`endif
    if (capture) begin
      out_valid_d = 1'b1;
      out_ch_d    = ch;
      sel_err_d   = out_of_range;
      out_data_d  = out_of_range ? '0 : node[ROOT];
`ifdef MUX_PARITY_EN
      out_par_d   = out_of_range ? 1'b0 : ^node[ROOT];
`endif
      if (bus.mode == MODE_SCAN) begin
        scan_cnt_d = (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
      end
    end else begin
      // Drain: data and channel keep their last values, only valid drops.
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (mode_edge) begin
        scan_cnt_d = '0;
      end
    end
  end

  // State registers with synchronous reset that wins over any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      scan_cnt_q  <= '0;
      mode_q      <= MODE_DIRECT;
`ifdef MUX_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      scan_cnt_q  <= scan_cnt_d;
      mode_q      <= bus.mode;
`ifdef MUX_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
`ifdef MUX_PARITY_EN
  assign bus.out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Self-checking bench for mux_nto1_scan: a 16-channel instance driven through
// a scoreboard and a 10-channel instance for out-of-range and wrap checks.
// Define MUX_PARITY_EN to also exercise out_par.
module tb_mux_nto1_scan;

  typedef struct {
    logic [3:0] ch;
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t       sb_q [$];
  logic [7:0] din_a [16];
  logic [3:0] m_cnt;
  logic       last_mode;

  always #5 clk = ~clk;

  mux_nto1_scan_if #(.NUM_CH(16), .DATA_W(8)) bus_a ();
  mux_nto1_scan_if #(.NUM_CH(10), .DATA_W(8)) bus_b ();

  mux_nto1_scan #(.NUM_CH(16), .DATA_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mux_nto1_scan #(.NUM_CH(10), .DATA_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic apply_din_a();
    for (int k = 0; k < 16; k++) bus_a.din[k*8 +: 8] = din_a[k];
  endtask

  // Present one transfer to DUT A, push its expected output when it is accepted.
  task automatic cap_a(input logic m, input logic [3:0] s);
    exp_t       e;
    logic [3:0] c;
    bit         done = 1'b0;
    if (m && !last_mode) m_cnt = 4'd0;
    last_mode      = m;
    bus_a.mode     = m;
    bus_a.sel      = s;
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) begin
        c      = m ? m_cnt : s;
        e.ch   = c;
        e.data = din_a[c];
        e.par  = ^din_a[c];
        sb_q.push_back(e);
        if (m) m_cnt = (m_cnt == 4'd15) ? 4'd0 : m_cnt + 4'd1;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("cap_timeout", 32'd0, 32'd1);
    else       check("lat_valid", 32'(bus_a.out_valid), 32'd1);
  endtask

  // One-cycle transfer into DUT B (its consumer is always ready).
  task automatic drive_b(input logic m, input logic [3:0] s);
    bus_b.mode     = m;
    bus_b.sel      = s;
    bus_b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic check_b(input string tag, input logic [3:0] ch, input logic [7:0] data, input logic err);
    check({tag, "_ch"},   32'(bus_b.out_ch),    32'(ch));
    check({tag, "_data"}, 32'(bus_b.out_data),  32'(data));
    check({tag, "_err"},  32'(bus_b.sel_err),   32'(err));
    check({tag, "_vld"},  32'(bus_b.out_valid), 32'd1);
`ifdef MUX_PARITY_EN
    check({tag, "_par"},  32'(bus_b.out_par),   32'(^data));
`endif
  endtask

  // Scoreboard side: compare DUT A's output whenever the consumer takes it.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && bus_a.out_valid && bus_a.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("mon_ch",   32'(bus_a.out_ch),   32'(e.ch));
        check("mon_data", 32'(bus_a.out_data), 32'(e.data));
        check("mon_err",  32'(bus_a.sel_err),  32'd0);
`ifdef MUX_PARITY_EN
        check("mon_par",  32'(bus_a.out_par),  32'(e.par));
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst             = 1'b1;
    bus_a.in_valid  = 1'b0;
    bus_a.mode      = 1'b0;
    bus_a.sel       = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.mode      = 1'b0;
    bus_b.sel       = '0;
    bus_b.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) din_a[k] = 8'hA0 + 8'(k);
    apply_din_a();
    for (int k = 0; k < 10; k++) bus_b.din[k*8 +: 8] = 8'h50 + 8'(k);
    m_cnt     = 4'd0;
    last_mode = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_data",  32'(bus_a.out_data),  32'd0);
    check("rst_ch",    32'(bus_a.out_ch),    32'd0);
    check("rst_err",   32'(bus_a.sel_err),   32'd0);
    check("rst_rdy",   32'(bus_a.in_ready),  32'd1);
    check("rst_b_vld", 32'(bus_b.out_valid), 32'd0);
    check("rst_b_err", 32'(bus_b.sel_err),   32'd0);
    rst = 1'b0;

    // Direct sweep over every channel, back to back.
    for (int s = 0; s < 16; s++) cap_a(1'b0, 4'(s));
    bus_a.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", 32'(bus_a.out_valid), 32'd0);
    check("drain_data",  32'(bus_a.out_data),  32'hAF);
    check("drain_ch",    32'(bus_a.out_ch),    32'd15);

    // Scan for 20 captures: 0..15 then wrap to 0..3.
    for (int i = 0; i < 20; i++) cap_a(1'b1, 4'd0);

    // Backpressure right after channel 3 was captured; din scrambled meanwhile.
    bus_a.out_ready = 1'b0;
    bus_a.din       = ~bus_a.din;
    repeat (5) begin
      @(negedge clk);
      check("hold_rdy",  32'(bus_a.in_ready),  32'd0);
      check("hold_vld",  32'(bus_a.out_valid), 32'd1);
      check("hold_data", 32'(bus_a.out_data),  32'hA3);
      check("hold_ch",   32'(bus_a.out_ch),    32'd3);
    end
    @(posedge clk);
    #1;
    apply_din_a();
    bus_a.out_ready = 1'b1;
    cap_a(1'b1, 4'd0);
    check("rel_ch4", 32'(bus_a.out_ch), 32'd4);
    cap_a(1'b1, 4'd0);
    check("rel_ch5", 32'(bus_a.out_ch), 32'd5);
    cap_a(1'b1, 4'd0);

    // Reset while holding valid data with the counter at 7; in_valid stays high.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_vld",  32'(bus_a.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus_a.out_data),  32'd0);
    check("mid_rst_ch",   32'(bus_a.out_ch),    32'd0);
    rst = 1'b0;
    sb_q.delete();
    m_cnt     = 4'd0;
    last_mode = 1'b0;
    cap_a(1'b1, 4'd0);
    check("post_rst_ch", 32'(bus_a.out_ch), 32'd0);
    bus_a.in_valid = 1'b0;

`ifdef MUX_PARITY_EN
    din_a[5] = 8'h07;
    din_a[6] = 8'h03;
    apply_din_a();
    cap_a(1'b0, 4'd5);
    check("par_ch5", 32'(bus_a.out_par), 32'd1);
    cap_a(1'b0, 4'd6);
    check("par_ch6", 32'(bus_a.out_par), 32'd0);
    bus_a.in_valid = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_left", 32'(sb_q.size()), 32'd0);

    // 10-channel instance: last valid select, out-of-range, recovery.
    drive_b(1'b0, 4'd9);
    check_b("b_sel9", 4'd9, 8'h59, 1'b0);
    drive_b(1'b0, 4'd12);
    check_b("b_sel12", 4'd12, 8'h00, 1'b1);
    drive_b(1'b0, 4'd10);
    check_b("b_sel10", 4'd10, 8'h00, 1'b1);
    drive_b(1'b0, 4'd2);
    check_b("b_sel2", 4'd2, 8'h52, 1'b0);

    // Short scan, then a direct capture that must not disturb the counter.
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 4'd0);
      check_b("b_scan", 4'(i), 8'h50 + 8'(i), 1'b0);
    end
    drive_b(1'b0, 4'd7);
    check_b("b_dir7", 4'd7, 8'h57, 1'b0);

    // Re-enter scan with no capture on the edge cycle: counter restarts at 0.
    bus_b.mode = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      drive_b(1'b1, 4'd0);
      check_b("b_wrap", 4'(i % 10), 8'h50 + 8'(i % 10), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer.
- Generalises the fixed 16:1 single-bit combinational mux.
- Adds a valid/ready output handshake, an auto-scan mode (internal round-robin channel counter) and out-of-range select detection.
- Sits between parallel sensor/data lanes and a single serial consumer in the lab datapath.

Parameters:
- NUM_CH, 16, number of input channels; 2..64, need not be a power of 2.
- DATA_W, 8, width of each channel in bits.
- SEL_W, $clog2(NUM_CH), select/channel-index width; derived, do not override.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  NUM_CH*DATA_W  packed channels; channel k is din[k*DATA_W +: DATA_W].
- in_valid  in  1  din is valid this cycle.
- in_ready  out  1  block can capture this cycle.
- mode  in  1  0 = direct (use sel), 1 = scan (internal counter).
- sel  in  SEL_W  channel select in direct mode; ignored in scan mode.
- out_data  out  DATA_W  registered selected data.
- out_ch  out  SEL_W  channel index that produced out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  consumer accepts this cycle.
- sel_err  out  1  registered; set when a captured direct-mode sel >= NUM_CH.

Behaviour:
- Reset (rst=1 at posedge): out_data=0, out_ch=0, out_valid=0, sel_err=0, scan counter=0, mode_q=0. Reset overrides any transfer in the same cycle.
- in_ready = !out_valid || out_ready (combinational; one-entry output register, no bubble).
- Capture when in_valid && in_ready:
  - Channel chosen: ch = mode ? scan_cnt : sel.
  - out_data <= din[ch], out_ch <= ch, out_valid <= 1.
  - Latency: 1 cycle from capture edge to out_valid.
- Hold when out_valid && !out_ready: out_data, out_ch and sel_err frozen; din changes are ignored.
- Drain: if out_valid && out_ready && !in_valid, then out_valid <= 0 and out_data/out_ch keep their last values.
- Scan counter:
  - Advances only on a capture in scan mode.
  - Wraps NUM_CH-1 -> 0 (explicit compare, not power-of-2 rollover).
- Mode edge: mode_q registers mode. On a 0->1 transition (mode && !mode_q) the current cycle's capture uses channel 0, and the counter then holds 1 if captured, else 0.
- Direct mode never changes the counter.
- Out of range, direct mode only (sel >= NUM_CH, possible when NUM_CH is not a power of 2):
  - out_data <= 0, out_ch <= sel, sel_err <= 1.
  - sel_err is cleared on the next capture with a valid sel.
- Simultaneous drain and capture in the same cycle: the new data replaces the old, and out_valid stays 1.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined: adds output port out_par (1 bit) = ^out_data.
  - Registered together with out_data; reset 0; frozen under backpressure.
  - Forced 0 on an out-of-range capture.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package mux_pkg:
  - localparam MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1.
  - function sel_width(n) returning clog2 with a minimum of 1.
- Sub-module mux_stage4: combinational W-bit 4:1 mux with a DATA_W parameter.
  - Top level builds the selection tree from it with a generate loop of ceil(log4(NUM_CH)) levels.
  - Unused leaves are tied to 0.

Test Plan:
- Direct sweep, NUM_CH=16, DATA_W=8, din[k]=8'hA0+k, out_ready=1, sel=0..15 with in_valid=1: out_data=A0..AF one cycle later, out_ch matches, sel_err=0.
- Scan wrap: mode=1, in_valid=1, out_ready=1 for 20 cycles. Expect out_ch sequence 0..15,0,1,2,3 and out_data=A0+out_ch.
- Backpressure: in scan mode, out_ready=0 for 5 cycles after the capture of ch 3. Expect out_data=A3 held, in_ready=0, counter stays 4. On release, the next outputs are ch 4 then ch 5.
- Out of range: NUM_CH=10, direct mode, sel=12. Expect out_data=0, out_ch=12, sel_err=1. The next capture with sel=2 gives out_data=din[2] and sel_err=0.
- Reset mid-scan: rst=1 while out_valid=1 and the counter is 7. Next cycle out_valid=0, out_data=0; the first scan capture afterwards is ch 0.
- With MUX_PARITY_EN defined: din[5]=8'h07, direct sel=5 gives out_par=1; din[6]=8'h03, sel=6 gives out_par=0.
